// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer
// Packs a 32-bit word stream into 512-bit blocks for chacha20_poly1305_core,
// issues each block with init (first of message) or next, captures the core
// result and streams it back out word by word with message framing.
// Only one block is ever in flight: input is closed from ISSUE to end of DRAIN.

module chacha_block_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  // input word stream
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  // core handshake
  output logic             core_init,
  output logic             core_next,
  output logic [511:0]     core_data_in,
  input  logic             core_ready,
  input  logic             core_valid,
  input  logic [511:0]     core_data_out,
  // output word stream
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Slot k of a block lives at packed index 15-k, i.e. bits [511-32k -: 32].
  logic [15:0][31:0] blk_buf_q;
  logic [15:0][31:0] out_buf_q;

  logic       running_q;   // low only in the first cycle after reset release
  logic [3:0] wr_idx_q;
  logic [3:0] rd_idx_q;
  logic [3:0] last_idx_q;  // n_words - 1 of the block in flight
  logic       last_blk_q;
  logic       first_blk_q;

  logic in_fire;
  logic closing;
  logic issue_fire;
  logic capture;
  logic out_fire;
  logic drain_done;

  assign s_ready      = running_q & (state_q == ST_FILL);
  assign m_valid      = (state_q == ST_DRAIN);
  assign m_data       = m_valid ? out_buf_q[4'd15 - rd_idx_q] : 32'd0;
  assign m_last       = m_valid & last_blk_q & (rd_idx_q == last_idx_q);
  assign core_data_in = blk_buf_q;

  assign in_fire    = s_valid & s_ready;
  assign closing    = in_fire & (s_last | (wr_idx_q == 4'd15));
  assign issue_fire = (state_q == ST_ISSUE) & core_ready;
  assign capture    = (state_q == ST_WAIT) & core_valid;
  assign out_fire   = m_valid & m_ready;
  assign drain_done = out_fire & (rd_idx_q == last_idx_q);

  // Next-state logic.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned; without it the tool would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (closing)    state_d = ST_ISSUE;
      ST_ISSUE: if (issue_fire) state_d = ST_WAIT;
      ST_WAIT:  if (capture)    state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_FILL;
      default:                  state_d = ST_FILL;
    endcase
  end

  // State register and the post-reset input enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FILL;
      running_q <= 1'b0;
    end else begin
      // NOTE: every register in a clocked block uses <= so all flops update
      // from the same pre-edge values regardless of statement order.
      state_q   <= state_d;
      running_q <= 1'b1;
    end
  end

  // Block buffer, indices, framing flags, core pulses and block counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_buf_q   <= '0;
      wr_idx_q    <= 4'd0;
      rd_idx_q    <= 4'd0;
      last_idx_q  <= 4'd0;
      last_blk_q  <= 1'b0;
      first_blk_q <= 1'b1;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;

      if (in_fire) begin
        blk_buf_q[4'd15 - wr_idx_q] <= s_data;
        wr_idx_q                    <= wr_idx_q + 4'd1;
        if (closing) begin
          last_idx_q <= wr_idx_q;
          last_blk_q <= s_last;
        end
      end

      if (issue_fire) begin
        if (first_blk_q) begin
          core_init <= 1'b1;
          blk_cnt   <= CNT_W'(1);
        end else begin
          core_next <= 1'b1;
          blk_cnt   <= blk_cnt + CNT_W'(1);
        end
        first_blk_q <= 1'b0;
      end

      if (capture) begin
        rd_idx_q <= 4'd0;
      end

      if (out_fire) begin
        if (drain_done) begin
          // Unfilled slots of the next block must read as zero.
          wr_idx_q  <= 4'd0;
          blk_buf_q <= '0;
          if (last_blk_q) begin
            first_blk_q <= 1'b1;
          end
        end else begin
          rd_idx_q <= rd_idx_q + 4'd1;
        end
      end
    end
  end

  // Result buffer, loaded once per block when the core answers.
  // NOTE: this datapath storage has no reset; it is only observed through
  // m_data, which is forced to zero whenever we are not in DRAIN.
  always_ff @(posedge clk) begin
    if (capture) begin
      out_buf_q <= core_data_out;
    end
  end

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Directed bench for chacha_block_sequencer with a behavioural core model
// that answers 10 cycles after each init/next with data_in ^ {16{A5A5A5A5}}.

module tb_chacha_block_sequencer;

  localparam logic [31:0] MASK = 32'hA5A5A5A5;

  logic         clk;
  logic         reset_n;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_data_in;
  logic         core_ready;
  logic         core_valid;
  logic [511:0] core_data_out;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic [15:0]  blk_cnt;

  chacha_block_sequencer #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .core_init     (core_init),
    .core_next     (core_next),
    .core_data_in  (core_data_in),
    .core_ready    (core_ready),
    .core_valid    (core_valid),
    .core_data_out (core_data_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .blk_cnt       (blk_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // core model drive and a manual override used by the reset test
  logic         model_valid;
  logic [511:0] model_data;
  logic         man_valid;
  logic [511:0] man_data;
  logic         core_mute;
  assign core_valid    = model_valid | man_valid;
  assign core_data_out = man_valid ? man_data : model_data;

  int           init_cnt;
  int           next_cnt;
  logic [511:0] cap_q[$];
  logic [31:0]  out_q[$];
  logic         last_q[$];
  logic [31:0]  exp_w[0:31];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts init/next and records the block presented with each.
  always @(negedge clk) begin
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
    if (core_init || core_next) cap_q.push_back(core_data_in);
  end

  // Output monitor: records every accepted output word.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      last_q.push_back(m_last);
    end
  end

  // Core model.
  initial begin
    logic [511:0] cap;
    model_valid = 1'b0;
    model_data  = '0;
    forever begin
      @(negedge clk);
      if ((core_init || core_next) && !core_mute) begin
        cap = core_data_in;
        repeat (9) @(posedge clk);
        #1;
        model_valid = 1'b1;
        model_data  = cap ^ {16{MASK}};
        @(posedge clk);
        #1;
        model_valid = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    int t;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {511'd0, s_ready}, 512'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_count"}, 512'(out_q.size()), 512'(n));
  endtask

  // Compares collected outputs against exp_w[] ^ MASK; m_last only on the final one.
  task automatic check_out(input string tag, input int n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), {480'd0, out_q[i]}, {480'd0, exp_w[i] ^ MASK});
      check($sformatf("%s_last%0d", tag, i), {511'd0, last_q[i]}, {511'd0, (i == n - 1)});
    end
  endtask

  task automatic clear_logs();
    init_cnt = 0;
    next_cnt = 0;
    cap_q.delete();
    out_q.delete();
    last_q.delete();
  endtask

  initial begin
    logic [15:0][31:0] exp_blk;
    logic [3:0]        pat;
    logic              sready_bad;
    logic              mvalid_bad;
    int                t;

    reset_n    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    core_ready = 1'b1;
    m_ready    = 1'b1;
    man_valid  = 1'b0;
    man_data   = '0;
    core_mute  = 1'b0;
    clear_logs();

    // ---------------- reset values ----------------
    #22;
    check("rst_s_ready",   {511'd0, s_ready},   512'd0);
    check("rst_core_init", {511'd0, core_init}, 512'd0);
    check("rst_core_next", {511'd0, core_next}, 512'd0);
    check("rst_m_valid",   {511'd0, m_valid},   512'd0);
    check("rst_m_last",    {511'd0, m_last},    512'd0);
    check("rst_m_data",    {480'd0, m_data},    512'd0);
    check("rst_blk_cnt",   {496'd0, blk_cnt},   512'd0);
    check("rst_data_in",   core_data_in,        512'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", {511'd0, s_ready}, 512'd1);

    // ---------------- single full block ----------------
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      exp_w[i]        = 32'(i + 1);
      exp_blk[15 - i] = 32'(i + 1);
    end
    for (int i = 0; i < 16; i++) push_word(exp_w[i], i == 15);
    check("full_data_in", core_data_in, exp_blk);
    wait_out("full", 16);
    check_out("full", 16);
    check("full_init_cnt", 512'(init_cnt), 512'd1);
    check("full_next_cnt", 512'(next_cnt), 512'd0);
    check("full_blk_cnt",  {496'd0, blk_cnt}, 512'd1);

    // ---------------- 20-word message ----------------
    clear_logs();
    for (int i = 0; i < 20; i++) exp_w[i] = 32'(i + 17 * (i / 16) * 0 + i + 1 - i);
    for (int i = 0; i < 20; i++) push_word(exp_w[i], i == 19);
    wait_out("msg20", 20);
    check_out("msg20", 20);
    check("msg20_init_cnt", 512'(init_cnt), 512'd1);
    check("msg20_next_cnt", 512'(next_cnt), 512'd1);
    check("msg20_blk_cnt",  {496'd0, blk_cnt}, 512'd2);
    exp_blk = '0;
    for (int i = 0; i < 4; i++) exp_blk[15 - i] = 32'(17 + i);
    if (cap_q.size() >= 2) check("msg20_blk1_in", cap_q[1], exp_blk);
    else check("msg20_cap_count", 512'(cap_q.size()), 512'd2);

    // ---------------- core_ready low for 5 cycles in ISSUE ----------------
    clear_logs();
    exp_w[0] = 32'h11111111;
    exp_w[1] = 32'h22222222;
    exp_blk = '0;
    exp_blk[15] = exp_w[0];
    exp_blk[14] = exp_w[1];
    push_word(exp_w[0], 1'b0);
    core_ready = 1'b0;
    push_word(exp_w[1], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_no_init%0d", i), {511'd0, core_init}, 512'd0);
      check($sformatf("stall_data_in%0d", i), core_data_in, exp_blk);
      @(posedge clk);
      #1;
    end
    core_ready = 1'b1;
    @(negedge clk);
    check("stall_no_init_rise", {511'd0, core_init}, 512'd0);
    @(negedge clk);
    check("stall_init_pulse", {511'd0, core_init}, 512'd1);
    check("stall_data_in_wait", core_data_in, exp_blk);
    @(negedge clk);
    check("stall_init_one_cycle", {511'd0, core_init}, 512'd0);
    wait_out("stall", 2);
    check_out("stall", 2);
    check("stall_init_cnt", 512'(init_cnt), 512'd1);

    // ---------------- output backpressure ----------------
    clear_logs();
    for (int i = 0; i < 4; i++) exp_w[i] = 32'(16 * (i + 1));
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(exp_w[i], i == 3);
    t = 0;
    while (!m_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("bp_m_valid_seen", {511'd0, m_valid}, 512'd1);
    pat = 4'b1001;  // m_ready sequence 1,0,0,1 read from bit 3 down
    sready_bad = 1'b0;
    t = 0;
    while (out_q.size() < 4 && t < 40) begin
      m_ready = pat[3 - (t % 4)];
      if (m_valid && s_ready) sready_bad = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    m_ready = 1'b1;
    check("bp_s_ready_low", {511'd0, sready_bad}, 512'd0);
    check("bp_s_ready_after", {511'd0, s_ready}, 512'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_dup", 512'(out_q.size()), 512'd4);
    check_out("bp", 4);

    // ---------------- reset mid-operation ----------------
    clear_logs();
    core_mute = 1'b1;
    push_word(32'h00000055, 1'b1);
    t = 0;
    while (!core_init && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_init_seen", {511'd0, core_init}, 512'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_s_ready", {511'd0, s_ready},   512'd0);
    check("rstmid_m_valid", {511'd0, m_valid},   512'd0);
    check("rstmid_blk_cnt", {496'd0, blk_cnt},   512'd0);
    check("rstmid_data_in", core_data_in,        512'd0);
    check("rstmid_init",    {511'd0, core_init}, 512'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    man_valid = 1'b1;
    man_data  = {512{1'b1}};
    @(posedge clk);
    #1;
    man_valid = 1'b0;
    mvalid_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid) mvalid_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    check("rstmid_late_valid_ignored", {511'd0, mvalid_bad}, 512'd0);
    core_mute = 1'b0;
    clear_logs();
    exp_w[0] = 32'h00000077;
    push_word(exp_w[0], 1'b1);
    wait_out("rstmid_next", 1);
    check_out("rstmid_next", 1);
    check("rstmid_next_init", 512'(init_cnt), 512'd1);
    check("rstmid_next_next", 512'(next_cnt), 512'd0);
    check("rstmid_blk_cnt1",  {496'd0, blk_cnt}, 512'd1);

    // ---------------- back-to-back single-word messages ----------------
    clear_logs();
    exp_w[0] = 32'hDEADBEEF;
    push_word(exp_w[0], 1'b1);
    wait_out("b2b_a", 1);
    check_out("b2b_a", 1);
    out_q.delete();
    last_q.delete();
    exp_w[0] = 32'hCAFEBABE;
    push_word(exp_w[0], 1'b1);
    wait_out("b2b_b", 1);
    check_out("b2b_b", 1);
    check("b2b_init_cnt", 512'(init_cnt), 512'd2);
    check("b2b_next_cnt", 512'(next_cnt), 512'd0);
    check("b2b_blk_cnt",  {496'd0, blk_cnt}, 512'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
